// File: rtl/gene_pkg.sv
// gene_pkg: base encodings and FSM state type shared by the sequence streamer.
package gene_pkg;
  typedef logic [1:0] base_t;
  localparam base_t BASE_A = 2'b00;
  localparam base_t BASE_C = 2'b01;
  localparam base_t BASE_G = 2'b10;
  localparam base_t BASE_T = 2'b11;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
endpackage

// File: rtl/gene_base_buf.sv
// gene_base_buf: DEPTH x 2-bit base store, synchronous write, asynchronous read.
module gene_base_buf import gene_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  base_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output base_t         rd_data
);
  base_t mem [DEPTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/gene_seq_streamer.sv
// gene_seq_streamer: buffers up to DEPTH bases, then streams them downstream with valid/ready.
module gene_seq_streamer import gene_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [1:0]    wr_base,
  input  logic          start,
  input  logic          abort,
  input  logic          base_ready,
  output logic [1:0]    base_out,
  output logic          base_valid,
  output logic          sof,
  output logic          eof,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] full_cnt = CW'(DEPTH);
  state_t state, state_n;
  logic [CW-1:0] count_n;
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic overflow_n, wr, xfer, last;
  base_t rd_data;
  gene_base_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .wr_en   (wr),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_base),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );
  assign wr         = state == IDLE && wr_en && count != full_cnt;
  assign base_valid = state == STREAM;
  assign base_out   = base_valid ? rd_data : BASE_A;
  assign last       = CW'(rd_ptr) == count - 1'b1;
  assign sof        = base_valid && rd_ptr == '0;
  assign eof        = base_valid && last;
  assign busy       = state != IDLE;
  assign done       = state == DONE;
  assign xfer       = base_valid && base_ready;
  // abort wins over a simultaneous transfer; count clears on entering DONE
  always_comb begin
    state_n    = state;
    count_n    = count;
    rd_ptr_n   = rd_ptr;
    overflow_n = overflow | (state == IDLE && wr_en && count == full_cnt);
    case (state)
      IDLE: begin
        if (wr) count_n = count + 1'b1;
        if (start) state_n = count_n != '0 ? STREAM : DONE;
      end
      STREAM: begin
        if (abort || (xfer && last)) begin
          state_n  = abort ? IDLE : DONE;
          count_n  = '0;
          rd_ptr_n = '0;
        end else if (xfer) rd_ptr_n = rd_ptr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      rd_ptr   <= rd_ptr_n;
      overflow <= overflow_n;
    end
endmodule

// File: tb/tb_gene_seq_streamer.sv
// tb_gene_seq_streamer: table-driven streams plus abort, reset and write+start corner sequences.
module tb_gene_seq_streamer;
  import gene_pkg::*;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, abort = 0, base_ready = 0;
  logic [1:0] wr_base = 0, base_out;
  logic base_valid, sof, eof, busy, done, overflow;
  logic [CW-1:0] count;
  int n_chk = 0, n_fail = 0;
  logic [1:0] mdl [$];
  logic [3:0] q [$];
  typedef struct {
    int n;
    logic [31:0] pat;
    logic [7:0] rpat;
    logic [CW-1:0] exp_cnt;
    logic exp_ovf;
  } vec_t;
  vec_t v [6];
  gene_seq_streamer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_base    (wr_base),
    .start      (start),
    .abort      (abort),
    .base_ready (base_ready),
    .base_out   (base_out),
    .base_valid (base_valid),
    .sof        (sof),
    .eof        (eof),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .overflow   (overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    chk("reset_outs", {base_out, base_valid, sof, eof, busy, done, overflow, count}, 0);
    @(negedge clk);
    rst = 0;
    mdl.delete();
    q.delete();
  endtask
  task automatic write_bases(input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      wr_en = 1;
      wr_base = pat[2*(i%16) +: 2];
      if (mdl.size() < DEPTH) mdl.push_back(wr_base);
      @(negedge clk);
    end
    wr_en = 0;
  endtask
  task automatic run_stream(input logic [7:0] rpat, input logic with_wr, input logic [1:0] wb);
    int n_exp, xf, dones;
    start = 1;
    if (with_wr) begin
      wr_en = 1;
      wr_base = wb;
      if (mdl.size() < DEPTH) mdl.push_back(wb);
    end
    foreach (mdl[i]) q.push_back({mdl[i], i == 0, i == mdl.size() - 1});
    n_exp = mdl.size();
    xf = 0;
    dones = 0;
    @(negedge clk);
    start = 0;
    wr_en = 0;
    for (int c = 0; c < 300; c++) begin
      base_ready = rpat[c%8];
      if (c == 0) chk("start_latency", base_valid, n_exp != 0);
      if (base_valid) begin
        chk("valid_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("stream_beat", {base_out, sof, eof}, q[0]);
          if (base_ready) begin
            void'(q.pop_front());
            xf++;
          end
        end
      end
      if (done) begin
        dones++;
        break;
      end
      @(negedge clk);
    end
    base_ready = 0;
    chk("transfers", xf, n_exp);
    chk("done_seen", dones, 1);
    @(negedge clk);
    chk("after_done", {done, busy, base_valid, count}, 0);
    mdl.delete();
    q.delete();
  endtask
  initial begin
    v[0] = '{4,  32'h0000_00E4, 8'hFF, 4, 0};
    v[1] = '{3,  32'h0000_002D, 8'hF9, 3, 0};
    v[2] = '{17, 32'h9C3A_57E1, 8'hB7, 16, 1};
    v[3] = '{0,  32'h0,         8'hFF, 0, 0};
    v[4] = '{1,  32'h0000_0002, 8'h06, 1, 0};
    v[5] = '{16, 32'h0123_4567, 8'h55, 16, 0};
    foreach (v[k]) begin
      do_reset();
      write_bases(v[k].n, v[k].pat);
      chk("count_after_writes", count, v[k].exp_cnt);
      chk("overflow_after_writes", overflow, v[k].exp_ovf);
      run_stream(v[k].rpat, 0, 0);
      chk("overflow_sticky", overflow, v[k].exp_ovf);
    end
    // write and start together: streamed length includes the new base
    do_reset();
    write_bases(2, 32'h9);
    run_stream(8'hFF, 1, BASE_T);
    // abort with a same-cycle transfer after two beats; writes during stream ignored
    do_reset();
    write_bases(5, 32'h0000_01B6);
    start = 1;
    @(negedge clk);
    start = 0;
    base_ready = 1;
    wr_en = 1;
    chk("abort_beat0", {base_valid, base_out, sof}, {1'b1, 2'b10, 1'b1});
    @(negedge clk);
    wr_en = 0;
    chk("abort_beat1", {base_valid, base_out, sof, eof}, {1'b1, 2'b01, 2'b00});
    chk("stream_write_ignored", {count, overflow}, {CW'(5), 1'b0});
    abort = 1;
    @(negedge clk);
    abort = 0;
    base_ready = 0;
    chk("after_abort", {base_valid, done, busy, count}, 0);
    @(negedge clk);
    chk("no_done_after_abort", {done, busy}, 0);
    // reset mid-stream, then a fresh stream
    write_bases(4, 32'h0000_001B);
    chk("count_before_rst", count, 4);
    start = 1;
    @(negedge clk);
    start = 0;
    base_ready = 1;
    chk("rst_beat0", {base_valid, base_out}, {1'b1, 2'b11});
    @(negedge clk);
    base_ready = 0;
    do_reset();
    chk("no_done_after_rst", {done, busy}, 0);
    write_bases(2, 32'h0000_0006);
    run_stream(8'hFF, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
